// File: rtl/cpu_ctrl_param_pkg.sv
// Shared definitions for the SIMPLE RISC controller.
// This file holds the FSM state encoding and the instruction classes.
// It also holds the opcode/op field values, the writeback-select codes
// and the one-hot register-select codes.
// The optional halt instruction is enabled by defining CPU_CTRL_HALT_EN.
// It is resolved in the decoder through the halt_en argument of classify().
package cpu_ctrl_param_pkg;

  // Controller states; S_HALT is only reachable when the halt option is built in
  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_GET_A  = 3'd2,
    S_GET_B  = 3'd3,
    S_ALU    = 3'd4,
    S_WR_C   = 3'd5,
    S_WR_IMM = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  // Instruction classes produced by the decoder
  typedef enum logic [2:0] {
    INS_ILL     = 3'd0,
    INS_MOV_IMM = 3'd1,
    INS_MOV_REG = 3'd2,
    INS_MVN     = 3'd3,
    INS_ADD     = 3'd4,
    INS_CMP     = 3'd5,
    INS_AND     = 3'd6,
    INS_HALT    = 3'd7
  } ins_t;

  // Opcode field IR[15:13]
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_HALT = 3'b111;

  // Op field IR[12:11]
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // Writeback mux select
  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  // One-hot register-field select: bit0 Rn, bit1 Rd, bit2 Rm
  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  // Map {opcode, op} to an instruction class; anything unrecognised is illegal
  function automatic ins_t classify(input logic [2:0] opcode,
                                    input logic [1:0] op,
                                    input logic       halt_en);
    ins_t result;
    result = INS_ILL;
    if (opcode == OPC_MOV && op == OP_MOV_IMM)      result = INS_MOV_IMM;
    else if (opcode == OPC_MOV && op == OP_MOV_REG) result = INS_MOV_REG;
    else if (opcode == OPC_ALU && op == OP_MVN)     result = INS_MVN;
    else if (opcode == OPC_ALU && op == OP_ADD)     result = INS_ADD;
    else if (opcode == OPC_ALU && op == OP_CMP)     result = INS_CMP;
    else if (opcode == OPC_ALU && op == OP_AND)     result = INS_AND;
    else if (halt_en && opcode == OPC_HALT)         result = INS_HALT;
    return result;
  endfunction

endpackage

// File: rtl/cpu_ctrl_param_instr_dec.sv
// Combinational instruction decoder.
// It splits the IR into its fields and classifies the instruction.
// It sign-extends the immediates to DATA_W.
// It steers Rn/Rd/Rm onto the register-file address lines from the one-hot nsel.
// When CPU_CTRL_HALT_EN is defined, opcode 111 decodes as HALT instead of illegal.
module cpu_ctrl_param_instr_dec
  import cpu_ctrl_param_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [15:0]       ir,
  input  logic [2:0]        nsel,
  output ins_t              ins,
  output logic [1:0]        alu_op,
  output logic [1:0]        shift_raw,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8
);

`ifdef CPU_CTRL_HALT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  logic [2:0] rn;
  logic [2:0] rd;
  logic [2:0] rm;
  logic [2:0] regnum;

  assign rn = ir[10:8];
  assign rd = ir[7:5];
  assign rm = ir[2:0];

  assign ins       = classify(ir[15:13], ir[12:11], HALT_EN);
  assign alu_op    = ir[12:11];
  assign shift_raw = ir[4:3];

  assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};
  assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};

  // AND-OR mux per address bit; nsel is one-hot, so at most one field wins
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_regsel
      assign regnum[gi] = (nsel[0] & rn[gi]) |
                          (nsel[1] & rd[gi]) |
                          (nsel[2] & rm[gi]);
    end
  endgenerate

  // Read and write ports share one register-field mux
  assign readnum  = regnum;
  assign writenum = regnum;

endmodule

// File: rtl/vDFFE.sv
// Load-enabled register with asynchronous active-low clear.
// It holds the instruction word for the controller.
module vDFFE #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d when enabled; clear immediately on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/cpu_ctrl_param.sv
// Controller for the SIMPLE RISC datapath: instruction register, decoder
// and Moore FSM. All datapath controls are decoded from the state register
// (and the IR, which is frozen while an instruction runs), so an
// asynchronous reset drops every strobe at once.
// Optional feature: define CPU_CTRL_HALT_EN to make opcode 111 enter a
// halt state that only reset_n leaves; otherwise opcode 111 is illegal.
module cpu_ctrl_param
  import cpu_ctrl_param_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s,
  input  logic              load,
  input  logic [15:0]       in,
  output logic              w,
  output logic              err,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              write,
  output logic [1:0]        vsel,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        ALUop,
  output logic [1:0]        shift,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8
);

  state_t      state_reg;
  logic [15:0] ir_reg;
  logic        ir_load;
  ins_t        ins;
  logic [1:0]  shift_raw;
  logic [2:0]  nsel;

  // The IR only accepts a new word while idle, so it stays stable for a whole instruction
  assign ir_load = load & (state_reg == S_WAIT);

  vDFFE #(
    .WIDTH (16)
  ) u_ir (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (ir_load),
    .d       (in),
    .q       (ir_reg)
  );

  cpu_ctrl_param_instr_dec #(
    .DATA_W (DATA_W)
  ) u_dec (
    .ir        (ir_reg),
    .nsel      (nsel),
    .ins       (ins),
    .alu_op    (ALUop),
    .shift_raw (shift_raw),
    .readnum   (readnum),
    .writenum  (writenum),
    .sximm5    (sximm5),
    .sximm8    (sximm8)
  );

  // State sequencing: one path per instruction class, always returning to S_WAIT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_WAIT;
    end else begin
      case (state_reg)
        S_WAIT: begin
          if (s) state_reg <= S_DECODE;
        end
        S_DECODE: begin
          case (ins)
            INS_MOV_IMM:                 state_reg <= S_WR_IMM;
            INS_MOV_REG, INS_MVN:        state_reg <= S_GET_B;
            INS_ADD, INS_CMP, INS_AND:   state_reg <= S_GET_A;
            INS_HALT:                    state_reg <= S_HALT;
            default:                     state_reg <= S_WAIT;
          endcase
        end
        S_GET_A:  state_reg <= S_GET_B;
        S_GET_B:  state_reg <= S_ALU;
        S_ALU: begin
          // CMP only updates the flags, so it skips the writeback
          if (ins == INS_CMP) state_reg <= S_WAIT;
          else                state_reg <= S_WR_C;
        end
        S_WR_C:   state_reg <= S_WAIT;
        S_WR_IMM: state_reg <= S_WAIT;
        S_HALT:   state_reg <= S_HALT;
        default:  state_reg <= S_WAIT;
      endcase
    end
  end

  // Datapath controls decoded from the current state
  always_comb begin
    w     = 1'b0;
    err   = 1'b0;
    write = 1'b0;
    vsel  = VSEL_C;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel  = 1'b0;
    bsel  = 1'b0;
    shift = 2'b00;
    nsel  = NSEL_NONE;
    case (state_reg)
      S_WAIT: begin
        w = 1'b1;
      end
      S_DECODE: begin
        err = (ins == INS_ILL);
      end
      S_GET_A: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      S_GET_B: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
        shift = shift_raw;
      end
      S_ALU: begin
        // MOV/MVN pass B through the ALU with A forced to zero
        shift = shift_raw;
        asel  = (ins == INS_MOV_REG) || (ins == INS_MVN);
        loadc = (ins != INS_CMP);
        loads = (ins == INS_CMP);
      end
      S_WR_C: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      S_WR_IMM: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_IMM8;
        write = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_param.sv
// Self-checking bench for cpu_ctrl_param (DATA_W=32).
// It compares the DUT against an instruction-level reference model.
// Define CPU_CTRL_HALT_EN to check the halt build instead of the illegal-opcode build.
module tb_cpu_ctrl_param;

  localparam int DATA_W = 32;

  typedef enum {K_MOV_IMM, K_MOV_REG, K_MVN, K_ADD, K_CMP, K_AND, K_HALT, K_ILL} kind_e;
  typedef enum {P_IDLE, P_DEC, P_RDA, P_RDB, P_EXE, P_WB, P_WIMM, P_HALT} step_e;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              s = 1'b0;
  logic              load = 1'b0;
  logic [15:0]       in_word = 16'h0000;
  logic              w, err, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]        readnum, writenum;
  logic [1:0]        vsel, ALUop, shift;
  logic [DATA_W-1:0] sximm5, sximm8;
  logic [20:0]       dut_vec;

  int          vectors = 0;
  int          miscompares = 0;
  int          txn = 0;
  logic [15:0] ir_model = 16'h0000;
  step_e       sched[$];

  cpu_ctrl_param #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n), .s(s), .load(load), .in(in_word),
    .w(w), .err(err), .readnum(readnum), .writenum(writenum), .write(write),
    .vsel(vsel), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .ALUop(ALUop), .shift(shift),
    .sximm5(sximm5), .sximm8(sximm8)
  );

  always #5 clk = ~clk;

  assign dut_vec = {w, err, write, loada, loadb, loadc, loads, asel, bsel,
                    vsel, readnum, writenum, shift, ALUop};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction class from the ISA table
  function automatic kind_e classify(input logic [15:0] word);
    case (word[15:11])
      5'b11010: return K_MOV_IMM;
      5'b11000: return K_MOV_REG;
      5'b10111: return K_MVN;
      5'b10100: return K_ADD;
      5'b10101: return K_CMP;
      5'b10110: return K_AND;
      default: begin
`ifdef CPU_CTRL_HALT_EN
        if (word[15:13] == 3'b111) return K_HALT;
`endif
        return K_ILL;
      end
    endcase
  endfunction

  // Cycles from the edge that accepts s until w is back high
  function automatic int spec_latency(input kind_e k);
    case (k)
      K_MOV_IMM:        return 3;
      K_MOV_REG, K_MVN: return 5;
      K_ADD, K_AND:     return 6;
      K_CMP:            return 5;
      default:          return 2;
    endcase
  endfunction

  function automatic int spec_writes(input kind_e k);
    case (k)
      K_MOV_IMM, K_MOV_REG, K_MVN, K_ADD, K_AND: return 1;
      default:                                   return 0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] sext(input logic [15:0] v, input int bits);
    int val;
    val = int'(v) & ((1 << bits) - 1);
    if (val >= (1 << (bits - 1))) val = val - (1 << bits);
    return DATA_W'(val);
  endfunction

  // Micro-step sequence each instruction class walks through after s
  task automatic build_sched(input kind_e k);
    sched.delete();
    sched.push_back(P_DEC);
    case (k)
      K_MOV_IMM: sched.push_back(P_WIMM);
      K_MOV_REG, K_MVN: begin
        sched.push_back(P_RDB); sched.push_back(P_EXE); sched.push_back(P_WB);
      end
      K_ADD, K_AND: begin
        sched.push_back(P_RDA); sched.push_back(P_RDB);
        sched.push_back(P_EXE); sched.push_back(P_WB);
      end
      K_CMP: begin
        sched.push_back(P_RDA); sched.push_back(P_RDB); sched.push_back(P_EXE);
      end
      default: begin
      end
    endcase
  endtask

  // Expected control vector for one micro-step of instruction ir
  function automatic logic [20:0] exp_vec(input step_e st, input logic [15:0] ir);
    logic       ew, eerr, ewr, ela, elb, elc, els, eas;
    logic [1:0] evs, esh;
    logic [2:0] ern;
    kind_e      k;
    k = classify(ir);
    {ew, eerr, ewr, ela, elb, elc, els, eas} = 8'h00;
    evs = 2'b00; esh = 2'b00; ern = 3'd0;
    case (st)
      P_IDLE: ew = 1'b1;
      P_DEC:  eerr = (k == K_ILL);
      P_RDA:  begin ela = 1'b1; ern = ir[10:8]; end
      P_RDB:  begin elb = 1'b1; ern = ir[2:0]; esh = ir[4:3]; end
      P_EXE:  begin
        esh = ir[4:3];
        eas = (k == K_MOV_REG) || (k == K_MVN);
        elc = (k != K_CMP);
        els = (k == K_CMP);
      end
      P_WB:   begin ewr = 1'b1; ern = ir[7:5]; evs = 2'b00; end
      P_WIMM: begin ewr = 1'b1; ern = ir[10:8]; evs = 2'b10; end
      default: begin
      end
    endcase
    return {ew, eerr, ewr, ela, elb, elc, els, eas, 1'b0, evs, ern, ern, esh, ir[12:11]};
  endfunction

  function automatic logic [15:0] gen_word();
    logic [15:0] word;
    int          r;
    word = 16'($urandom);
    r = $urandom_range(0, 7);
    case (r)
      0: word[15:11] = 5'b11010;
      1: word[15:11] = 5'b11000;
      2: word[15:11] = 5'b10111;
      3: word[15:11] = 5'b10100;
      4: word[15:11] = 5'b10101;
      5: word[15:11] = 5'b10110;
      default: begin
        while (classify(word) != K_ILL) word = 16'($urandom);
      end
    endcase
    return word;
  endfunction

  // Issue one instruction from S_WAIT and follow it back to idle
  task automatic run_instr(input logic [15:0] word, input bit same_cycle);
    kind_e k;
    int    cyc;
    int    writes;
    bit    done;
    k = classify(word);
    check_eq("idle", dut_vec, exp_vec(P_IDLE, ir_model));
    if (!same_cycle) begin
      in_word = word; load = 1'b1; s = 1'b0;
      tick();
      ir_model = word;
      check_eq("preload", dut_vec, exp_vec(P_IDLE, ir_model));
      load = 1'b0; in_word = 16'($urandom); s = 1'b1;
    end else begin
      in_word = word; load = 1'b1; s = 1'b1;
    end
    build_sched(k);
    ir_model = word;
    cyc = 0; writes = 0; done = 1'b0;
    while (!done) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        check_eq("sximm5", sximm5, sext(word, 5));
        check_eq("sximm8", sximm8, sext(word, 8));
      end
      if (write) writes++;
      if (w) begin
        done = 1'b1;
      end else if (cyc > 30) begin
        check_eq("timeout", cyc, spec_latency(k));
        done = 1'b1;
      end else begin
        if (cyc <= sched.size())
          check_eq($sformatf("step%0d", cyc), dut_vec, exp_vec(sched[cyc-1], word));
        else
          check_eq("overrun", dut_vec, exp_vec(P_IDLE, word));
        // Busy: s/load/in must all be ignored
        s = 1'($urandom); load = 1'($urandom); in_word = 16'($urandom);
      end
    end
    s = 1'b0; load = 1'b0;
    check_eq("latency", cyc, spec_latency(k));
    check_eq("writes", writes, spec_writes(k));
    check_eq("ret_idle", dut_vec, exp_vec(P_IDLE, ir_model));
    $display("txn %0d in=%h kind=%s lat=%0d writes=%0d", txn, word, k.name(), cyc, writes);
    txn++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_vec", dut_vec, exp_vec(P_IDLE, 16'h0000));
    check_eq("rst_sximm8", sximm8, '0);
    @(negedge clk) reset_n = 1'b1;
    tick();

    run_instr(16'hD3FB, 1'b1);   // MOV R3,#-5
    run_instr(16'hA148, 1'b0);   // ADD R2,R1,R0,LSL#1
    run_instr(16'hA902, 1'b1);   // CMP R1,R2

    // Reset while ADD sits in S_GET_B
    in_word = 16'hA148; load = 1'b1; s = 1'b1;
    tick();
    load = 1'b0; s = 1'b0;
    tick();
    tick();
    check_eq("rst_pre_getb", dut_vec, exp_vec(P_RDB, 16'hA148));
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_mid_w", w, 1'b1);
    check_eq("rst_mid_loadb", loadb, 1'b0);
    check_eq("rst_mid_write", write, 1'b0);
    check_eq("rst_mid_ir", sximm8, '0);
    @(negedge clk) reset_n = 1'b1;
    tick();
    ir_model = 16'h0000;
    check_eq("rst_after", dut_vec, exp_vec(P_IDLE, ir_model));
    $display("txn %0d reset mid-instruction done", txn);
    txn++;

    repeat (150) run_instr(gen_word(), 1'($urandom_range(0, 1)));

`ifdef CPU_CTRL_HALT_EN
    in_word = 16'hE000; load = 1'b1; s = 1'b1;
    tick();
    check_eq("halt_dec", dut_vec, exp_vec(P_DEC, 16'hE000));
    repeat (20) begin
      s = 1'($urandom); load = 1'($urandom); in_word = 16'($urandom);
      tick();
      check_eq("halt_hold", dut_vec, exp_vec(P_HALT, 16'hE000));
    end
    s = 1'b0; load = 1'b0;
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    tick();
    ir_model = 16'h0000;
    check_eq("halt_exit", dut_vec, exp_vec(P_IDLE, ir_model));
    $display("txn %0d halt held 20 cycles, left by reset", txn);
`else
    run_instr(16'hE000, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
